// File: rtl/im2col_pkg.sv
// Shared constants and state encoding for the im2col window controllers.
package im2col_pkg;
  localparam int IMG_H    = 28;
  localparam int IMG_W    = 28;
  localparam int K        = 3;
  localparam int ROWS_OUT = IMG_H - K + 1;
  localparam int COLS_OUT = IMG_W - K + 1;
  localparam int ADDR_W   = 5;

  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(ROWS_OUT - 1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(COLS_OUT - 1);

  typedef enum logic {IDLE, RUN} sched_state_e;
endpackage

// File: rtl/im2col_rc_cnt.sv
// Row/column nested counter: load-zero, park (ROW_MAX,0), step on enable.
// Priority load_zero > park > enable; resets to the parked position.
module im2col_rc_cnt #(
  parameter int             W       = 5,
  parameter logic [W-1:0]   ROW_MAX = '1,
  parameter logic [W-1:0]   COL_MAX = '1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_load_zero,
  input  logic         i_park,
  output logic [W-1:0] o_row,
  output logic [W-1:0] o_col,
  output logic         o_last
);
  logic [W-1:0] row_q, row_d;
  logic [W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (i_load_zero) begin
      row_d = '0;
      col_d = '0;
    end else if (i_park) begin
      row_d = ROW_MAX;
      col_d = '0;
    end else if (i_en) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = row_q + W'(1);
      end else begin
        col_d = col_q + W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      row_q <= ROW_MAX;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign o_row  = row_q;
  assign o_col  = col_q;
  assign o_last = (row_q == ROW_MAX) && (col_q == COL_MAX);
endmodule

// File: rtl/im2col_win_sched.sv
// 3x3 window sweep sequencer for the 28x28 row buffer; first window 1 cycle after image valid,
// window held under !i_win_ready. Optional stall counter: IM2COL_WIN_SCHED_STALL_CNT_EN.
module im2col_win_sched
  import im2col_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_img_valid,
  output logic              o_img_ready,
  output logic [ADDR_W-1:0] o_row,
  output logic [ADDR_W-1:0] o_col,
  output logic              o_win_valid,
  input  logic              i_win_ready,
  output logic              o_first,
  output logic              o_last,
  output logic              o_busy
`ifdef IM2COL_WIN_SCHED_STALL_CNT_EN
  ,output logic [15:0]      o_stall_cnt
`endif
);
  sched_state_e state_q;
  logic         win_fire;
  logic         start;
  logic         finish;
  logic         cnt_last;

  assign o_win_valid = (state_q == RUN);
  assign o_busy      = (state_q == RUN);
  assign win_fire    = o_win_valid & i_win_ready;
  assign start       = (state_q == IDLE) & i_img_valid;
  assign finish      = win_fire & cnt_last;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else if (state_q == IDLE) begin
      if (i_img_valid) state_q <= RUN;
    end else if (finish) begin
      state_q <= IDLE;
    end
  end

  // Parking on the final fire leaves the row address at ROW_LAST so the buffer can reload.
  im2col_rc_cnt #(
    .W       (ADDR_W),
    .ROW_MAX (ROW_LAST),
    .COL_MAX (COL_LAST)
  ) u_rc_cnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_en        (win_fire),
    .i_load_zero (start),
    .i_park      (finish),
    .o_row       (o_row),
    .o_col       (o_col),
    .o_last      (cnt_last)
  );

  assign o_first     = o_win_valid && (o_row == '0) && (o_col == '0);
  assign o_last      = o_win_valid && cnt_last;
  assign o_img_ready = win_fire & o_last;

`ifdef IM2COL_WIN_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else if (start) begin
      stall_cnt_q <= '0;
    end else if (o_win_valid && !i_win_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

  a_img_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (state_q == RUN) |-> i_img_valid);
  a_in_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_row <= ROW_LAST) && (o_col <= COL_LAST));
endmodule
